// File: rtl/tcm_link_pkg.sv
// Shared types and constants for the TCM trigger link.
//   BC_MAX_DEFAULT : last bunch-crossing number of an orbit before wrap to 0
//   HDR_TAG/PAY_TAG: fixed tags in the upper bits of header / payload words
//   trig_evt_t     : one captured trigger event (17 bits)
//   framer_state_t : output framer FSM states
package tcm_link_pkg;

    localparam int         BC_MAX_DEFAULT = 3563;
    localparam logic [3:0] HDR_TAG        = 4'hA;
    localparam logic [7:0] PAY_TAG        = 8'h5C;

    typedef struct packed {
        logic        tt;
        logic        ta;
        logic [2:0]  phase;
        logic [11:0] bc;
    } trig_evt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } framer_state_t;

endpackage

// File: rtl/trig_evt_fifo.sv
// Synchronous FIFO of trig_evt_t records.
//   clk, rstn : clock, asynchronous active-low reset (pointers/level only)
//   push, din : write request and record
//   pop, dout : remove head; dout always shows the head (read without removal)
//   full/empty/level : occupancy status, level in 0..DEPTH
// A pop and a push in the same cycle on a full FIFO both succeed: the pop
// frees the slot first, so the push is never refused in that case.
module trig_evt_fifo
    import tcm_link_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  trig_evt_t       din,
    input  logic            pop,
    output trig_evt_t       dout,
    output logic            full,
    output logic            empty,
    output logic [LW-1:0]   level
);

    trig_evt_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Storage carries data only; no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

endmodule

// File: rtl/tcm_trig_framer.sv
// Captures tcm_req trigger events with phase and bunch-crossing number,
// buffers them and emits two-word frames (header, payload) to the TCM link.
//   clk320, rstn       : 320 MHz clock, asynchronous active-low reset
//   mt_cou             : phase 0..7 within the 25 ns bunch
//   tcm_req, tt, ta    : trigger request and its trigger bits
//   orbit_sync         : restarts the bunch-crossing count at 0
//   link_data/valid    : frame word toward the serializer
//   link_ready         : sink accepts the word
//   fifo_level         : buffered events, including the one being framed
//   ovf_cnt            : events lost to a full buffer, saturating at 255
module tcm_trig_framer
    import tcm_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BC_MAX     = BC_MAX_DEFAULT
) (
    input  logic        clk320,
    input  logic        rstn,
    input  logic [2:0]  mt_cou,
    input  logic        tcm_req,
    input  logic        tt,
    input  logic        ta,
    input  logic        orbit_sync,
    output logic [15:0] link_data,
    output logic        link_valid,
    input  logic        link_ready,
    output logic [2:0]  fifo_level,
    output logic [7:0]  ovf_cnt
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [11:0]   bc;
    logic          last_vld;
    logic [11:0]   last_bc;
    logic          cap_evt;
    logic          push_ok;
    logic          drop;
    trig_evt_t     evt_in;
    trig_evt_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [LW-1:0] fifo_lvl;
    framer_state_t state;
    framer_state_t state_nxt;

    // Bunch-crossing counter; orbit_sync has priority over the phase-7 step.
    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn)                bc <= '0;
        else if (orbit_sync)      bc <= '0;
        else if (mt_cou == 3'd7)  bc <= (bc == 12'(BC_MAX)) ? '0 : bc + 12'd1;
    end

    // At most one event per bunch: a request in the bunch of the last
    // captured event is ignored. last_vld starts clear so the first request
    // after reset always passes.
    assign cap_evt = tcm_req && !(last_vld && (last_bc == bc));
    assign evt_in  = {tt, ta, mt_cou, bc};

    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn) begin
            last_vld <= 1'b0;
            last_bc  <= '0;
        end else if (cap_evt) begin
            last_vld <= 1'b1;
            last_bc  <= bc;
        end
    end

    assign fifo_pop = (state == PAY) && link_ready;
    assign push_ok  = cap_evt && (!fifo_full || fifo_pop);
    assign drop     = cap_evt && fifo_full && !fifo_pop;

    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn)     ovf_cnt <= '0;
        else if (drop) ovf_cnt <= sat_inc8(ovf_cnt);
    end

    trig_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk320),
        .rstn  (rstn),
        .push  (cap_evt),
        .din   (evt_in),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

    assign fifo_level = 3'(fifo_lvl);

    // Output framer. Outputs decode the state directly so an asynchronous
    // reset drops link_valid without waiting for a clock edge.
    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        link_valid = 1'b0;
        link_data  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = HDR;
            end
            HDR: begin
                link_valid = 1'b1;
                link_data  = {HDR_TAG, head.bc};
                if (link_ready) state_nxt = PAY;
            end
            PAY: begin
                link_valid = 1'b1;
                link_data  = {PAY_TAG, 3'b000, head.tt, head.ta, head.phase};
                // A same-cycle push keeps the stream gap-free.
                if (link_ready)
                    state_nxt = ((fifo_lvl > LW'(1)) || push_ok) ? HDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tcm_trig_framer.sv
module tb_tcm_trig_framer;

    logic        clk320 = 1'b0;
    logic        rstn;
    logic [2:0]  mt_cou;
    logic        tcm_req;
    logic        tt;
    logic        ta;
    logic        orbit_sync;
    logic [15:0] link_data;
    logic        link_valid;
    logic        link_ready;
    logic [2:0]  fifo_level;
    logic [7:0]  ovf_cnt;

    int          total = 0;
    int          bad   = 0;
    int          mbc   = 0;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    logic        hold = 1'b0;
    logic [15:0] hold_data = '0;

    tcm_trig_framer #(.FIFO_DEPTH(4), .BC_MAX(3563)) dut (
        .clk320     (clk320),
        .rstn       (rstn),
        .mt_cou     (mt_cou),
        .tcm_req    (tcm_req),
        .tt         (tt),
        .ta         (ta),
        .orbit_sync (orbit_sync),
        .link_data  (link_data),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk320 = ~clk320;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Link monitor: records transferred words and checks that a stalled
    // word stays valid and unchanged until accepted.
    always @(negedge clk320) begin
        if (!rstn) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                check("hold_vld", 32'(link_valid), 32'd1);
                check("hold_data", 32'(link_data), 32'(hold_data));
            end
            if (link_valid && link_ready) got_q.push_back(link_data);
            hold      <= link_valid && !link_ready;
            hold_data <= link_data;
        end
    end

    // One clock: update the bc reference from the pre-edge inputs, step,
    // then advance the phase and clear single-cycle pulses.
    task automatic tick();
        if (!rstn)                mbc = 0;
        else if (orbit_sync)      mbc = 0;
        else if (mt_cou == 3'd7)  mbc = (mbc == 3563) ? 0 : mbc + 1;
        @(posedge clk320);
        #1;
        mt_cou     = mt_cou + 3'd1;
        tcm_req    = 1'b0;
        orbit_sync = 1'b0;
    endtask

    // Advance until the next edge will see bunch b at phase p.
    task automatic goto(input int b, input logic [2:0] p, input bit rnd);
        int n = 0;
        while (!(mbc == b && mt_cou == p) && n < 40000) begin
            if (rnd) link_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (n >= 40000) check("goto_bc", 32'(mbc), 32'(b));
    endtask

    task automatic req(input logic t, input logic a);
        tt      = t;
        ta      = a;
        tcm_req = 1'b1;
        tick();
    endtask

    task automatic cmp_words(input string tag);
        check({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rstn = 1'b0; mt_cou = '0; tcm_req = 1'b0; tt = 1'b0; ta = 1'b0;
        orbit_sync = 1'b0; link_ready = 1'b0;
        repeat (3) tick();
        check("rst_vld", 32'(link_valid), 32'd0);
        check("rst_data", 32'(link_data), 32'd0);
        check("rst_lvl", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        rstn = 1'b1;
        link_ready = 1'b1;

        // Single event, latency and word contents
        goto(5, 3'd3, 0);
        req(1'b1, 1'b0);
        check("t1_lvl1", 32'(fifo_level), 32'd1);
        check("t1_vld0", 32'(link_valid), 32'd0);
        tick();
        check("t1_hvld", 32'(link_valid), 32'd1);
        check("t1_hdr", 32'(link_data), 32'hA005);
        tick();
        check("t1_pay", 32'(link_data), 32'h5C13);
        tick();
        check("t1_vld_end", 32'(link_valid), 32'd0);
        check("t1_lvl_end", 32'(fifo_level), 32'd0);
        exp_q = '{16'hA005, 16'h5C13};
        cmp_words("t1_words");

        // Same-bunch duplicate
        goto(10, 3'd1, 0);
        req(1'b0, 1'b1);
        tick(); tick();
        req(1'b1, 1'b1);
        repeat (12) tick();
        check("t2_ovf", 32'(ovf_cnt), 32'd0);
        check("t2_lvl", 32'(fifo_level), 32'd0);
        exp_q = '{16'hA00A, 16'h5C09};
        cmp_words("t2_words");

        // Overflow under back-pressure
        link_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            goto(20 + i, 3'd2, 0);
            req(1'(i & 1), 1'((i >> 1) & 1));
        end
        check("t3_lvl", 32'(fifo_level), 32'd4);
        check("t3_ovf", 32'(ovf_cnt), 32'd2);
        check("t3_hdr", 32'(link_data), 32'hA014);
        link_ready = 1'b1;
        repeat (14) tick();
        check("t3_lvl_end", 32'(fifo_level), 32'd0);
        exp_q = '{16'hA014, 16'h5C02, 16'hA015, 16'h5C12,
                  16'hA016, 16'h5C0A, 16'hA017, 16'h5C1A};
        cmp_words("t3_words");

        // BC wrap
        goto(3563, 3'd5, 0);
        req(1'b1, 1'b1);
        goto(0, 3'd2, 0);
        req(1'b0, 1'b1);
        repeat (10) tick();
        exp_q = '{16'hADEB, 16'h5C1D, 16'hA000, 16'h5C0A};
        cmp_words("t4_wrap");

        // orbit_sync restart
        goto(100, 3'd1, 0);
        req(1'b0, 1'b0);
        goto(100, 3'd3, 0);
        orbit_sync = 1'b1;
        tick();
        goto(0, 3'd6, 0);
        req(1'b1, 1'b0);
        repeat (10) tick();
        exp_q = '{16'hA064, 16'h5C01, 16'hA000, 16'h5C16};
        cmp_words("t4_sync");

        // Random ready: order and integrity under stalls
        goto(10, 3'd0, 1);
        req(1'b1, 1'b0);
        goto(15, 3'd0, 1);
        req(1'b0, 1'b1);
        goto(20, 3'd0, 1);
        req(1'b1, 1'b1);
        repeat (20) begin
            link_ready = 1'($urandom_range(0, 1));
            tick();
        end
        link_ready = 1'b1;
        repeat (12) tick();
        exp_q = '{16'hA00A, 16'h5C10, 16'hA00F, 16'h5C08, 16'hA014, 16'h5C18};
        cmp_words("t5_rand");

        // Reset in the middle of a frame
        link_ready = 1'b0;
        goto(40, 3'd0, 0);
        req(1'b1, 1'b1);
        tick();
        check("t6_hdr", 32'(link_data), 32'hA028);
        link_ready = 1'b1;
        tick();
        link_ready = 1'b0;
        check("t6_pay", 32'(link_data), 32'h5C18);
        rstn = 1'b0;
        #1;
        check("t6_vld_async", 32'(link_valid), 32'd0);
        check("t6_data_rst", 32'(link_data), 32'd0);
        check("t6_lvl_rst", 32'(fifo_level), 32'd0);
        check("t6_ovf_rst", 32'(ovf_cnt), 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        link_ready = 1'b1;
        repeat (10) tick();
        check("t6_vld_idle", 32'(link_valid), 32'd0);
        goto(2, 3'd0, 0);
        req(1'b0, 1'b0);
        repeat (8) tick();
        exp_q = '{16'hA028, 16'hA002, 16'h5C00};
        cmp_words("t6_words");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
